// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the ID-stage hazard controller:
// stall-cause codes, MIPS register field positions and FSM states.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_LOAD   = 2'b01,
        CAUSE_BRANCH = 2'b10,
        CAUSE_HOLD   = 2'b11
    } stall_cause_e;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // Wide enough for any LOAD_LAT-1 in the legal 1..15 range.
    localparam int REM_W = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Compares one producer register against the rs/rt operands of the ID instruction;
// register 0 is hardwired to zero in MIPS and can never be a dependency.
module hazard_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_reg,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic              i_uses_rs,
    input  logic              i_uses_rt,
    output logic              o_match
);

    assign o_match = (i_reg != '0) &&
                     ((i_uses_rs && (i_reg == i_rs)) || (i_uses_rt && (i_reg == i_rt)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use and branch-operand stalls, multi-cycle
// load latency hold, taken-branch IF/ID flush and a saturating stall counter.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int INSTR_W      = 32,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               id_uses_rs_i,
    input  logic               id_uses_rt_i,
    input  logic               id_is_branch_i,
    input  logic               branch_taken_i,
    input  logic               idex_memread_i,
    input  logic               idex_regwrite_i,
    input  logic [REG_AW-1:0]  idex_rd_i,
    input  logic               exmem_memread_i,
    input  logic [REG_AW-1:0]  exmem_rd_i,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               bubble_o,
    output logic               ifid_flush_o,
    output logic [1:0]         stall_cause_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(LOAD_LAT - 1);

    hz_state_e          r_state;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [REG_AW-1:0]  w_rs;
    logic [REG_AW-1:0]  w_rt;
    logic               w_unused_instr;
    logic               w_m_ex_load;
    logic               w_m_ex_write;
    logic               w_m_mem_load;
    logic               w_hz_load;
    logic               w_hz_br;
    logic               w_hazard;
    logic               w_hold_res;
    logic               w_stall;

    assign w_rs           = REG_AW'(instr_i[RS_MSB:RS_LSB]);
    assign w_rt           = REG_AW'(instr_i[RT_MSB:RT_LSB]);
    assign w_unused_instr = ^instr_i;

    hazard_match #(.REG_AW(REG_AW)) u_match_ex_load (
        .i_reg     (idex_rd_i),
        .i_rs      (w_rs),
        .i_rt      (w_rt),
        .i_uses_rs (id_uses_rs_i),
        .i_uses_rt (id_uses_rt_i),
        .o_match   (w_m_ex_load)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_ex_write (
        .i_reg     (idex_rd_i),
        .i_rs      (w_rs),
        .i_rt      (w_rt),
        .i_uses_rs (id_uses_rs_i),
        .i_uses_rt (id_uses_rt_i),
        .o_match   (w_m_ex_write)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_mem_load (
        .i_reg     (exmem_rd_i),
        .i_rs      (w_rs),
        .i_rt      (w_rt),
        .i_uses_rs (id_uses_rs_i),
        .i_uses_rt (id_uses_rt_i),
        .o_match   (w_m_mem_load)
    );

    assign w_hz_load  = idex_memread_i && w_m_ex_load;
    assign w_hz_br    = (BRANCH_IN_ID != 0) && id_is_branch_i &&
                        ((idex_regwrite_i && w_m_ex_write) || (exmem_memread_i && w_m_mem_load));
    assign w_hazard   = w_hz_load || w_hz_br;
    assign w_hold_res = (r_state == ST_HOLD) && (r_rem != '0);
    assign w_stall    = w_hazard || w_hold_res;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_rem       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_hz_load && (LOAD_LAT > 1)) begin
                        r_state <= ST_HOLD;
                        r_rem   <= REM_RELOAD;
                    end
                end
                ST_HOLD: begin
                    // A fresh load only restarts the latency once the previous one has drained.
                    if ((r_rem == '0) && w_hz_load) begin
                        r_rem <= REM_RELOAD;
                    end else if (r_rem != '0) begin
                        r_rem <= r_rem - 1'b1;
                    end else if (!w_hazard) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_rem   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        bubble_o      = 1'b1;
        ifid_flush_o  = 1'b0;
        stall_cause_o = CAUSE_NONE;
        if (!rst_i) begin
            pc_write_o   = !w_stall;
            ifid_write_o = !w_stall;
            bubble_o     = w_stall;
            ifid_flush_o = branch_taken_i && !w_stall;
            if (w_hz_load) begin
                stall_cause_o = CAUSE_LOAD;
            end else if (w_hz_br) begin
                stall_cause_o = CAUSE_BRANCH;
            end else if (w_hold_res) begin
                stall_cause_o = CAUSE_HOLD;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule
